// File: rtl/seven_seg_scanner_pkg.sv
// Shared widths, limits and FSM encoding for the seven-segment scanner.
// Build option: SCAN_ERR_DISPLAY_EN (out-of-range values display as "EEEE").
package seven_seg_pkg;
    localparam int DIGIT_W    = 5;
    localparam int EXP_W      = 3;
    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [BIN_W-1:0]   MAX_VAL  = 14'd9999;
    localparam logic [DIGIT_W-1:0] ERR_CODE = 5'h1F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;
endpackage

// File: rtl/seven_seg_scanner_bin2bcd.sv
// Iterative double-dabble converter: one add-3/shift step per clock, BIN_W steps total.
// last_shift is high during the cycle whose edge performs the final shift.
module bin2bcd_iter
    import seven_seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             last_shift
);
    logic [BCD_W-1:0] bcd_reg;
    logic [BIN_W-1:0] bin_reg;
    logic [3:0]       cnt_reg;
    logic             active_reg;
    logic [BCD_W-1:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign last_shift = active_reg && (cnt_reg == 4'(BIN_W - 1));
    assign bcd        = bcd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_reg    <= '0;
            bin_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            bcd_reg    <= '0;
            bin_reg    <= bin;
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
            cnt_reg            <= cnt_reg + 4'd1;
            if (last_shift)
                active_reg <= 1'b0;
        end
    end
endmodule

// File: rtl/seven_seg_scanner.sv
// Binary-to-BCD display source: converts a captured value and scans its four digits.
// Build option: SCAN_ERR_DISPLAY_EN (values above 9999 commit ERR_CODE instead of clamping).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BIN_W-1:0]   value,
    output logic [DIGIT_W-1:0] digit,
    output logic [EXP_W-1:0]   exp,
    output logic               busy,
    output logic               done,
    output logic               overflow
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t             state_reg, state_next;
    logic               busy_reg, done_reg, overflow_reg;
    logic [CNT_W-1:0]   refresh_cnt_reg, refresh_cnt_next;
    logic [1:0]         sel_reg, sel_next;
    logic [DIGIT_W-1:0] digit_reg;
    logic [DIGIT_W-1:0] display_reg  [NUM_DIGITS];
    logic [DIGIT_W-1:0] display_next [NUM_DIGITS];
    logic               start, last_shift, show_err, value_big;
    logic [BIN_W-1:0]   bin_in;
    logic [BCD_W-1:0]   bcd;

    assign start     = (state_reg == IDLE) && load;
    assign value_big = value > MAX_VAL;

`ifdef SCAN_ERR_DISPLAY_EN
    logic err_reg;
    assign bin_in   = value;
    assign show_err = err_reg;
    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else if (start)
            err_reg <= value_big;
    end
`else
    assign bin_in   = value_big ? MAX_VAL : value;
    assign show_err = 1'b0;
`endif

    bin2bcd_iter u_bin2bcd (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bin        (bin_in),
        .bcd        (bcd),
        .last_shift (last_shift)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = CONVERT;
            CONVERT: if (last_shift) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Display registers only move on COMMIT, so a half-converted value is never visible.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
            assign display_next[gi] = (state_reg != COMMIT) ? display_reg[gi] :
                                      show_err ? ERR_CODE : {1'b0, bcd[gi*4 +: 4]};
        end
    endgenerate

    always_comb begin
        refresh_cnt_next = refresh_cnt_reg + 1'b1;
        sel_next         = sel_reg;
        if (refresh_cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt_next = '0;
            sel_next         = sel_reg + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
            refresh_cnt_reg <= '0;
            sel_reg         <= '0;
            digit_reg       <= '0;
            display_reg     <= '{default: '0};
        end else begin
            state_reg       <= state_next;
            refresh_cnt_reg <= refresh_cnt_next;
            sel_reg         <= sel_next;
            display_reg     <= display_next;
            // Look ahead through both muxes so digit and exp always agree.
            digit_reg       <= display_next[sel_next];
            done_reg        <= (state_reg == COMMIT);
            if (start) begin
                busy_reg     <= 1'b1;
                overflow_reg <= value_big;
            end else if (state_reg == COMMIT) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign digit    = digit_reg;
    assign exp      = {1'b0, sel_reg};
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overflow = overflow_reg;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with a fast refresh divider.
module tb_seven_seg_scanner;
    localparam int REFRESH_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic [4:0]  digit;
    logic [2:0]  exp;
    logic        busy, done, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] exp_q [$];
    int          m_cnt = 0;
    int          m_exp = 0;

    seven_seg_scanner #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .digit(digit), .exp(exp), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference scan position.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_exp <= 0;
        end else if (m_cnt == REFRESH_DIV - 1) begin
            m_cnt <= 0;
            m_exp <= (m_exp + 1) % 4;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [19:0] expect_digits(input int v);
        logic [19:0] r;
        int          x;
        x = v;
        if (v > 9999) begin
`ifdef SCAN_ERR_DISPLAY_EN
            return {4{5'h1F}};
`else
            x = 9999;
`endif
        end
        r[4:0]   = 5'(x % 10);
        r[9:5]   = 5'((x / 10) % 10);
        r[14:10] = 5'((x / 100) % 10);
        r[19:15] = 5'((x / 1000) % 10);
        return r;
    endfunction

    task automatic drive_load(input int v);
        load  = 1'b1;
        value = 14'(v);
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Measures cycles until done and how many of them had busy set.
    task automatic wait_done(output int lat, output int busy_cycles, output bit timeout);
        lat = 0; busy_cycles = 0; timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (digit !== 5'd0 || exp !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: digit=%0d exp=%0d busy=%b done=%b ovf=%b, required all 0",
                     digit, exp, busy, done, overflow);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (exp !== 3'(m_exp) || digit !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_scan cycle %0d: exp=%0d digit=%0d, required exp=%0d digit=0",
                         i, exp, digit, m_exp);
            end
        end
        $display("reset: scan sequence observed over 20 cycles");
    endtask

    task automatic test_load(input int v, input string name);
        int lat, bc;
        bit to;
        logic [19:0] e;
        drive_load(v);
        exp_q.push_back(expect_digits(v));
        wait_done(lat, bc, to);
        n_checks++;
        if (to || lat != 15 || bc != 15) begin
            n_fail++;
            $display("FAIL %s_timing: done after %0d cycles, busy %0d cycles, timeout=%b, required 15/15/0",
                     name, lat, bc, to);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (busy !== 1'b0 || overflow !== (v > 9999)) begin
            n_fail++;
            $display("FAIL %s_flags: busy=%b overflow=%b, required busy=0 overflow=%b",
                     name, busy, overflow, v > 9999);
        end
        for (int i = 0; i < 4 * REFRESH_DIV; i++) begin
            n_checks++;
            if (exp !== 3'(m_exp) || digit !== e[m_exp*5 +: 5] || (i == 1 && done !== 1'b0)) begin
                n_fail++;
                $display("FAIL %s_digits: exp=%0d digit=%0d done=%b, required exp=%0d digit=%0d",
                         name, exp, digit, done, m_exp, e[m_exp*5 +: 5]);
            end
            @(negedge clk);
        end
        $display("load %s: value=%0d expected digits %0d %0d %0d %0d ovf=%b",
                 name, v, e[19:15], e[14:10], e[9:5], e[4:0], v > 9999);
    endtask

    task automatic test_back_to_back;
        int lat, bc, extra_done;
        bit to;
        logic [19:0] e;
        drive_load(5678);
        exp_q.push_back(expect_digits(5678));
        repeat (4) @(negedge clk);
        drive_load(1111);
        wait_done(lat, bc, to);
        n_checks++;
        if (to || lat != 10) begin
            n_fail++;
            $display("FAIL b2b_timing: done %0d cycles after ignored load (timeout=%b), required 10",
                     lat, to);
        end
        e = exp_q.pop_front();
        extra_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0 && done) extra_done++;
            n_checks++;
            if (exp !== 3'(m_exp) || digit !== e[m_exp*5 +: 5]) begin
                n_fail++;
                $display("FAIL b2b_digits: exp=%0d digit=%0d, required exp=%0d digit=%0d",
                         exp, digit, m_exp, e[m_exp*5 +: 5]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (extra_done != 0) begin
            n_fail++;
            $display("FAIL b2b_extra_done: %0d extra done pulses, required 0", extra_done);
        end
        $display("back_to_back: 5678 then ignored 1111, display expected 5678");
    endtask

    task automatic test_reset_abort;
        int dones;
        test_load(1234, "pre_abort");
        drive_load(9876);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || digit !== 5'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b digit=%0d done=%b, required 0/0/0", busy, digit, done);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dones++;
            n_checks++;
            if (busy !== 1'b0 || digit !== 5'd0 || exp !== 3'(m_exp)) begin
                n_fail++;
                $display("FAIL abort_display: busy=%b digit=%0d exp=%0d, required busy=0 digit=0 exp=%0d",
                         busy, digit, exp, m_exp);
            end
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_done: %0d done pulses after reset, required 0", dones);
        end
        $display("reset_abort: conversion of 9876 aborted at cycle 7, display expected 0000");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load(1234, "v1234");
        test_load(9999, "v9999");
        test_load(0, "v0");
        test_back_to_back();
        test_load(12000, "v12000");
        test_load(42, "v42_after_ovf");
        test_load(16383, "v16383");
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
